mem_arbiter: RTL
================

# mem_arbiter

Two-port SRAM access controller that shares the single 16-bit asynchronous SRAM between the CPU microsequencer port and a DMA/loader port. It arbitrates round-robin and sequences each access through address-setup, strobe and hold phases. It drives registered, glitch-free active-low `notCS`/`notOE`/`notWE` strobes plus address and write data. It sits between the requesters and the `sram` model, replacing direct microcode control of the memory strobes.

## Interface
- `STROBE_CYCLES`, default 1: number of cycles `notOE`/`notWE` are held low; legal range 1..15.
- `clock` in 1: system clock; all state changes on the rising edge.
- `notReset` in 1: asynchronous, active-low reset.
- `cpuReq` in 1: CPU access request; level, held until `cpuAck`.
- `cpuWrite` in 1: 1 = write, 0 = read; stable while `cpuReq` is high.
- `cpuAddr` in 16: CPU word address.
- `cpuWData` in 16: CPU write data.
- `cpuRData` out 16: read data returned to the CPU.
- `cpuAck` out 1: one-cycle completion pulse.
- `dmaReq`, `dmaWrite`, `dmaAddr[15:0]`, `dmaWData[15:0]`, `dmaRData[15:0]`, `dmaAck`: same meanings as the CPU port, for the DMA port.
- `memAddr` out 16: SRAM address.
- `memWData` out 16: data driven toward the SRAM.
- `memDataOE` out 1: enables the external tri-state driver of `memWData` onto the data bus.
- `memRData` in 16: SRAM read data.
- `memNotCS`, `memNotOE`, `memNotWE` out 1 each: active-low SRAM strobes.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE → SETUP when any request is high at the edge.
  - SETUP → STROBE after 1 cycle.
  - STROBE → HOLD after `STROBE_CYCLES` cycles.
  - HOLD → IDLE after 1 cycle.
- Arbitration:
  - Evaluated only in IDLE.
  - If one request is high, that port wins.
  - If both are high, the port not granted last wins.
  - `lastGrant` resets to DMA, so the CPU wins the first tie.
- On grant, register the winner's `addr`, `write` and `wdata`, and the grant ID. Requester inputs are not sampled again during the access.
- Strobe levels per state:
  - SETUP: `memNotCS`=0; `memNotOE`/`memNotWE`=1.
  - STROBE: `memNotCS`=0; read drives `memNotOE`=0, write drives `memNotWE`=0.
  - HOLD: `memNotCS`=0; `memNotOE`/`memNotWE`=1.
  - IDLE: all strobes 1.
- `memDataOE`=1 from SETUP through HOLD for writes only. It is never 1 during a read.
- Read capture: `memRData` is captured into the granted port's `RData` register at the edge ending the last STROBE cycle. It holds that value until that port's next read.
- Ack: the granted port's `Ack`=1 during HOLD only. The other port's `Ack` stays 0.
- A request still high in IDLE after its ack is a new access; back-to-back accesses by the same port are allowed.
- A request dropped before ack does not abort the access. The access completes and the ack is still pulsed.
- Reset values: state IDLE; `memNotCS`, `memNotOE`, `memNotWE` = 1; `memDataOE`, both acks and `busy` = 0; `memAddr`, `memWData`, `cpuRData`, `dmaRData` = 0; `lastGrant` = DMA.
- Reset mid-access: strobes deassert asynchronously; no ack is issued; the access is lost.

## Timing
- All outputs are registered; strobes never glitch between states.
- Request high before edge E0 in IDLE:
  - SETUP spans E0–E1.
  - STROBE spans E1–E1+N, where N = `STROBE_CYCLES`.
  - HOLD (ack) spans E1+N–E2+N.
  - IDLE follows; with the default N=1, ack is sampled at E3.
- One access occupies 3+N cycles including the IDLE arbitration cycle.
- Address and write data are stable for the whole SETUP through HOLD window. This gives one full cycle of setup and one of hold around each strobe.
- Starvation bound: with both ports requesting continuously, each port waits at most one access (3+N cycles) between grants.

## Structure
- Package `mem_arb_pkg`:
  - state encoding (IDLE, SETUP, STROBE, HOLD);
  - port ID constants (`PORT_CPU`=0, `PORT_DMA`=1);
  - strobe-counter width of 4 bits.
- Sub-module `rr_picker`: 2-way round-robin choice from `cpuReq`, `dmaReq` and `lastGrant`, producing the grant ID and a valid flag.
- The main module holds the FSM, strobe counter, latched request fields and read-data registers.

## Test plan
- CPU read, N=1, SRAM[0x0010]=0xBEEF: `cpuReq` with addr 0x0010. Required: `memNotOE` low exactly 1 cycle, `cpuAck` pulses in the 3rd cycle after the request is sampled, `cpuRData`=0xBEEF, `dmaAck` stays 0.
- DMA write of 0x1234 to 0xFFF0, N=3: `memNotWE` low for exactly 3 cycles, `memDataOE` high for 5 cycles, then CPU read of 0xFFF0 returns 0x1234.
- Both ports requesting continuously from reset: grants alternate CPU, DMA, CPU, DMA…; each ack is spaced 3+N cycles apart; neither port gets two consecutive grants.
- Request dropped in STROBE: access still completes, ack still pulses once, and the next IDLE shows no grant.
- `notReset` pulled low during STROBE of a write: `memNotWE`, `memNotCS` and `memNotOE` go to 1 without waiting for a clock edge, no ack is issued, state is IDLE after release, and the first tie goes to the CPU.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM encoding, port IDs, strobe-counter width.
// Pure definitions; no latency or flow-control behaviour of its own.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int CNT_W = 4;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin choice between CPU and DMA requests; combinational, zero latency.
// No backpressure: a requester simply keeps its level request high until it is picked.
module rr_picker
   import mem_arb_pkg::*;
(
   input  logic cpu_req,
   input  logic dma_req,
   input  logic last_grant,
   output logic grant_id,
   output logic grant_vld
);

   always_comb begin
      grant_vld = cpu_req | dma_req;
      grant_id  = PORT_CPU;
      if (cpu_req && dma_req) begin
         grant_id = (last_grant == PORT_DMA) ? PORT_CPU : PORT_DMA;
      end else if (dma_req) begin
         grant_id = PORT_DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one async SRAM between CPU and DMA ports: IDLE/SETUP/STROBE/HOLD, 3+STROBE_CYCLES cycles per access.
// Requesters hold a level request until their one-cycle ack in HOLD; the loser waits at most one access.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STROBE_CYCLES = 1
)
(
   input  logic        clock,
   input  logic        notReset,
   input  logic        cpuReq,
   input  logic        cpuWrite,
   input  logic [15:0] cpuAddr,
   input  logic [15:0] cpuWData,
   output logic [15:0] cpuRData,
   output logic        cpuAck,
   input  logic        dmaReq,
   input  logic        dmaWrite,
   input  logic [15:0] dmaAddr,
   input  logic [15:0] dmaWData,
   output logic [15:0] dmaRData,
   output logic        dmaAck,
   output logic [15:0] memAddr,
   output logic [15:0] memWData,
   output logic        memDataOE,
   input  logic [15:0] memRData,
   output logic        memNotCS,
   output logic        memNotOE,
   output logic        memNotWE,
   output logic        busy
);

   localparam cnt_t STROBE_LOAD = cnt_t'(STROBE_CYCLES - 1);

   state_t      state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_q, grant_d;
   logic        write_q, write_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] cpu_rdata_q, cpu_rdata_d;
   logic [15:0] dma_rdata_q, dma_rdata_d;
   logic        cs_n_q, cs_n_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic        data_oe_q, data_oe_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        dma_ack_q, dma_ack_d;
   logic        busy_q, busy_d;

   logic        pick_id;
   logic        pick_vld;

   rr_picker u_rr_picker (
      .cpu_req    (cpuReq),
      .dma_req    (dmaReq),
      .last_grant (last_grant_q),
      .grant_id   (pick_id),
      .grant_vld  (pick_vld)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d      = ST_SETUP;
               grant_d      = pick_id;
               last_grant_d = pick_id;
               if (pick_id == PORT_CPU) begin
                  write_d = cpuWrite;
                  addr_d  = cpuAddr;
                  wdata_d = cpuWData;
               end else begin
                  write_d = dmaWrite;
                  addr_d  = dmaAddr;
                  wdata_d = dmaWData;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = STROBE_LOAD;
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               // Data is sampled while OE is still low, at the edge closing the strobe.
               if (!write_q) begin
                  if (grant_q == PORT_CPU) cpu_rdata_d = memRData;
                  else                     dma_rdata_d = memRData;
               end
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes are decoded from the next state so every output comes straight off a flop.
      cs_n_d    = (state_d == ST_IDLE);
      oe_n_d    = !((state_d == ST_STROBE) && !write_d);
      we_n_d    = !((state_d == ST_STROBE) && write_d);
      data_oe_d = (state_d != ST_IDLE) && write_d;
      cpu_ack_d = (state_d == ST_HOLD) && (grant_d == PORT_CPU);
      dma_ack_d = (state_d == ST_HOLD) && (grant_d == PORT_DMA);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= PORT_DMA;
         grant_q      <= PORT_CPU;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         cs_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         data_oe_q    <= 1'b0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         cs_n_q       <= cs_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         data_oe_q    <= data_oe_d;
         cpu_ack_q    <= cpu_ack_d;
         dma_ack_q    <= dma_ack_d;
         busy_q       <= busy_d;
      end
   end

   assign memAddr   = addr_q;
   assign memWData  = wdata_q;
   assign memDataOE = data_oe_q;
   assign memNotCS  = cs_n_q;
   assign memNotOE  = oe_n_q;
   assign memNotWE  = we_n_q;
   assign cpuRData  = cpu_rdata_q;
   assign dmaRData  = dma_rdata_q;
   assign cpuAck    = cpu_ack_q;
   assign dmaAck    = dma_ack_q;
   assign busy      = busy_q;

endmodule
